// File: rtl/switch_debounce.sv
// switch_debounce
//   Turns the raw, bouncing board push-button into clean clk-synchronous events:
//   an input synchroniser, a four-state debounce FSM, press/release pulses, a
//   long-press pulse and an optional auto-repeat pulse.
//
// Parameters
//   SYNC_STAGES      flops in the synchroniser chain (>= 2)
//   ACTIVE_LOW       1: raw low means pressed, 0: raw high means pressed
//   DEBOUNCE_CYCLES  stable synchronised cycles needed to accept a change (>= 1)
//   LONG_CYCLES      cycles held in PRESSED after the press pulse before long_press (>= 1)
//   REPEAT_CYCLES    auto-repeat period after long_press (only with SWITCH_REPEAT_EN)
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   sw_raw         in   raw switch pad, asynchronous and bouncing
//   level          out  debounced state, 1 = pressed
//   press          out  1-cycle pulse on accepted press
//   release_pulse  out  1-cycle pulse on accepted release (bare "release" is a reserved word)
//   long_press     out  1-cycle pulse once per press after LONG_CYCLES held
//   repeat_pulse   out  1-cycle auto-repeat pulse (bare "repeat" is a reserved word)
//
// Build option
//   SWITCH_REPEAT_EN  when defined, repeat_pulse fires every REPEAT_CYCLES in PRESSED
//                     after long_press; when undefined repeat_pulse is tied to 0 and
//                     no repeat counter exists.
module switch_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 160000,
  parameter int LONG_CYCLES     = 16000000,
  parameter int REPEAT_CYCLES   = 3200000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_chk_long
    $error("LONG_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_chk_rep
    $error("REPEAT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   sw_norm;
  logic                   sync_p;
  logic                   deb_done;

  // Stage: normalise polarity and synchronise (1 = pressed from here on)
  assign sw_norm = (ACTIVE_LOW != 0) ? ~sw_raw : sw_raw;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sw_norm};
  end

  assign sync_p   = sync_q[SYNC_STAGES-1];
  assign deb_done = (deb_cnt_q >= DEB_MAX);

  // Stage: debounce FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (sync_p) state_d = PRESS_WAIT;
      PRESS_WAIT:   if (!sync_p) state_d = IDLE;
                    else if (deb_done) state_d = PRESSED;
      PRESSED:      if (!sync_p) state_d = RELEASE_WAIT;
      RELEASE_WAIT: if (sync_p) state_d = PRESSED;
                    else if (deb_done) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Stage: counters and output pulses
  // deb_cnt counts the samples seen so far in the candidate new level; the
  // change is accepted on the sample after it reaches DEBOUNCE_CYCLES.
  // hold_q counts cycles spent in PRESSED only, so a bounce into RELEASE_WAIT
  // freezes it; it saturates at LONG_CYCLES, which also marks "long seen".
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        deb_cnt_d = sync_p ? DEB_W'(1) : '0;
      end
      PRESS_WAIT: begin
        if (!sync_p) begin
          deb_cnt_d = '0;
        end else if (deb_done) begin
          deb_cnt_d = '0;
          press_d   = 1'b1;
          level_d   = 1'b1;
          hold_d    = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      PRESSED: begin
        deb_cnt_d = sync_p ? '0 : DEB_W'(1);
        if (hold_q == HOLD_FIRE) long_d = 1'b1;
        if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
      end
      RELEASE_WAIT: begin
        if (sync_p) begin
          deb_cnt_d = '0;
        end else if (deb_done) begin
          deb_cnt_d = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        deb_cnt_d = '0;
      end
    endcase
  end

  // Synchroniser flops preset to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      deb_cnt_q <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_cnt_q <= deb_cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

`ifdef SWITCH_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_FIRE = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             repeat_q, repeat_d;

  // Stage: auto-repeat, counting PRESSED cycles after long_press has fired
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    repeat_d  = 1'b0;
    if (press_d || release_d) begin
      rep_cnt_d = '0;
    end else if ((state_q == PRESSED) && (hold_q == HOLD_MAX)) begin
      if (rep_cnt_q == REP_FIRE) begin
        rep_cnt_d = '0;
        repeat_d  = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
